// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: md_op command codes and FSM states.
package md_ctrl_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Commands that occupy the unit for a multi-cycle latency
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/md_counter.sv
// Loadable down-counter with zero/one flags; models the latency of the mult/div unit.
module md_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_one
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_one  = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models unit latency, raises stall_md to hazard logic.
// Build option MD_ABORT_EN adds an abort input that flushes an in-flight operation.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | unit free; accepts MULT/MULTU/DIV/DIVU, performs MTHI/MTLO
// ST_RUN  | op in flight; counter running, pending HI/LO commit at count 1
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use,
`ifdef MD_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e r_state;
    md_state_e w_state_nxt;

    logic        w_abort;
    logic        w_is_arith;
    logic        w_is_div;
    logic        w_idle;
    logic        w_accept;
    logic        w_mt_we;
    logic        w_cnt_load;
    logic        w_cnt_clr;
    logic        w_cnt_zero;
    logic        w_cnt_one;
    logic        w_commit;
    logic [CNT_W-1:0] w_cnt_init;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_we;

`ifdef MD_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_is_arith = md_is_arith(md_op);
    assign w_is_div   = (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = w_idle && start && w_is_arith && !w_abort;
    assign w_mt_we    = w_idle && start && ((md_op == MD_MTHI) || (md_op == MD_MTLO)) && !w_abort;
    assign w_cnt_init = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    md_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_cnt_clr),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_init),
        .i_dec      (busy),
        .o_zero     (w_cnt_zero),
        .o_one      (w_cnt_one)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort outranks a coincident commit; a zero count in RUN is a recovery path only
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_load  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                end else if (w_cnt_one) begin
                    w_state_nxt = ST_IDLE;
                    w_commit    = 1'b1;
                end else if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Arithmetic on the operands presented at the accepting edge
    logic [63:0] w_rs_sx;
    logic [63:0] w_rt_sx;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_sdiv;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_rs_sx  = {{32{rs_val[31]}}, rs_val};
    assign w_rt_sx  = {{32{rt_val[31]}}, rt_val};
    assign w_prod_s = w_rs_sx * w_rt_sx;
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide done on magnitudes so 0x80000000 needs no special width
    assign w_sdiv = (md_op == MD_DIV);
    assign w_dvd  = (w_sdiv && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
    assign w_dvs  = (w_sdiv && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
    assign w_uq   = (w_dvs == 32'd0) ? 32'd0 : (w_dvd / w_dvs);
    assign w_ur   = (w_dvs == 32'd0) ? 32'd0 : (w_dvd % w_dvs);
    assign w_q    = (w_sdiv && (rs_val[31] ^ rt_val[31])) ? (32'd0 - w_uq) : w_uq;
    assign w_r    = (w_sdiv && rs_val[31]) ? (32'd0 - w_ur) : w_ur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else if (w_accept) begin
            case (md_op)
                MD_MULT: begin
                    r_pend_hi <= w_prod_s[63:32];
                    r_pend_lo <= w_prod_s[31:0];
                    r_pend_we <= 1'b1;
                end
                MD_MULTU: begin
                    r_pend_hi <= w_prod_u[63:32];
                    r_pend_lo <= w_prod_u[31:0];
                    r_pend_we <= 1'b1;
                end
                default: begin
                    r_pend_hi <= w_r;
                    r_pend_lo <= w_q;
                    r_pend_we <= (rt_val != 32'd0);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (r_pend_we) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (w_mt_we) begin
            if (md_op == MD_MTHI) begin
                r_hi <= rs_val;
            end else begin
                r_lo <= rs_val;
            end
        end
    end

    assign busy     = (r_state == ST_RUN);
    assign stall_md = md_use && (busy || (start && w_is_arith));
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed and random ops against a longint reference model.
// Abort scenarios are exercised when MD_ABORT_EN is defined.
module tb_md_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        md_use = 1'b0;
`ifdef MD_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    md_ctrl #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC),
        .CNT_W       (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .md_use   (md_use),
`ifdef MD_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    // The hazard unit never issues a command while the unit is busy
    always @(negedge clk) begin
        if (rst_n && start && busy) begin
            n_errors++;
            $error("FAIL start_while_busy observed start=1 busy=1 expected no start");
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: results from plain 64-bit arithmetic; returns unit latency
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        lat = 0;
        case (op)
            3'd0: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
                lat = MC;
            end
            3'd1: begin
                up = ua * ub;
                m_hi = up[63:32];
                m_lo = up[31:0];
                lat = MC;
            end
            3'd2: begin
                if (b != 32'd0) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
                lat = DC;
            end
            3'd3: begin
                if (b != 32'd0) begin
                    uq = ua / ub;
                    ur = ua % ub;
                    m_lo = uq[31:0];
                    m_hi = ur[31:0];
                end
                lat = DC;
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: lat = 0;
        endcase
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d, input string tag);
        logic [31:0] oh, ol;
        int          lat;
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        md_use = use_d;
        #1;
        check($sformatf("%s_stall_accept", tag), 32'(stall_md), 32'(use_d && (op <= 3'd3)));
        check($sformatf("%s_busy_accept", tag), 32'(busy), 32'd0);
        oh = m_hi;
        ol = m_lo;
        model_op(op, a, b, lat);
        @(posedge clk);
        #1;
        start  = 1'b0;
        md_op  = 3'($urandom);
        rs_val = $urandom;
        rt_val = $urandom;
        for (int i = 0; i < lat; i++) begin
            check($sformatf("%s_busy_c%0d", tag, i + 1), 32'(busy), 32'd1);
            check($sformatf("%s_stall_c%0d", tag, i + 1), 32'(stall_md), 32'(use_d));
            check($sformatf("%s_hi_hold_c%0d", tag, i + 1), hi, oh);
            check($sformatf("%s_lo_hold_c%0d", tag, i + 1), lo, ol);
            @(posedge clk);
            #1;
        end
        check($sformatf("%s_busy_done", tag), 32'(busy), 32'd0);
        check($sformatf("%s_stall_done", tag), 32'(stall_md), 32'd0);
        check($sformatf("%s_hi", tag), hi, m_hi);
        check($sformatf("%s_lo", tag), lo, m_lo);
    endtask

`ifdef MD_ABORT_EN
    task automatic do_abort(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int k, input string tag);
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        md_use = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i < k; i++) begin
            @(posedge clk);
            #1;
        end
        check($sformatf("%s_busy_before", tag), 32'(busy), 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check($sformatf("%s_busy_after", tag), 32'(busy), 32'd0);
        check($sformatf("%s_hi", tag), hi, m_hi);
        check($sformatf("%s_lo", tag), lo, m_lo);
        repeat (DC) @(posedge clk);
        #1;
        check($sformatf("%s_hi_late", tag), hi, m_hi);
        check($sformatf("%s_lo_late", tag), lo, m_lo);
    endtask
`endif

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_stall", 32'(stall_md), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1, "mult");
        check("mult_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_lo_const", lo, 32'hFFFF_FFFE);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");
        check("multu_hi_const", hi, 32'h0000_0001);
        check("multu_lo_const", lo, 32'hFFFF_FFFE);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, "div");
        check("div_hi_const", hi, 32'hFFFF_FFFF);
        check("div_lo_const", lo, 32'hFFFF_FFFD);
        do_op(3'd3, 32'd7, 32'd0, 1'b1, "divu_by0");
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        do_op(3'd5, 32'h1234_5678, 32'd0, 1'b1, "mtlo");
        check("mtlo_lo_const", lo, 32'h1234_5678);
        do_op(3'd4, 32'hCAFE_0001, 32'd0, 1'b1, "mthi_a");
        do_op(3'd4, 32'hCAFE_0002, 32'd0, 1'b1, "mthi_b");
        do_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b1, "nop6");
        do_op(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, "nop7");

        // Async reset in the middle of a MULT: clears immediately, nothing commits later
        @(negedge clk);
        start  = 1'b1;
        md_op  = 3'd0;
        rs_val = 32'd3;
        rt_val = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_hi", hi, 32'd0);
        check("rstmid_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rstmid_busy_late", 32'(busy), 32'd0);
        check("rstmid_hi_late", hi, 32'd0);
        check("rstmid_lo_late", lo, 32'd0);

`ifdef MD_ABORT_EN
        do_op(3'd0, 32'd1000, 32'd77, 1'b0, "pre_abort");
        do_abort(3'd2, 32'd100, 32'd7, 4, "abort_div");
        do_abort(3'd0, 32'd5, 32'd9, MC, "abort_final");
        @(negedge clk);
        start  = 1'b1;
        md_op  = 3'd4;
        rs_val = 32'h5555_AAAA;
        abort  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_mthi_hi", hi, m_hi);
        check("abort_mthi_busy", 32'(busy), 32'd0);
`endif

        repeat (30) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 4) == 0) ? 32'd0 :
                   ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            do_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
